// File: rtl/booth2_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier controller.
// Optional early termination is enabled by defining BOOTH2_SEQ_MUL_EARLY_TERM_EN.
package booth2_pkg;

    localparam int WIDTH1 = 16;
    localparam int STEPS  = WIDTH1 / 2;
    localparam int PP_W   = WIDTH1 + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit interpretation: low digits are unsigned 0..3, the top digit is signed -2..1.
    localparam logic DIGIT_UNSIGNED = 1'b0;
    localparam logic DIGIT_SIGNED   = 1'b1;

endpackage

// File: rtl/booth2_seq_mul_ctrl_pp_gen.sv
// Combinational partial-product generator: pp = A * digit, exact at width1+2 bits.
// Interface matches the 2-bit layer so a LUT/carry-chain version can drop in later.
module booth2_pp_gen
    import booth2_pkg::*;
#(
    parameter int width1 = WIDTH1
) (
    input  logic signed [width1-1:0] a_i,
    input  logic        [1:0]        digit_i,
    input  logic                     last_step_i,
    output logic signed [width1+1:0] pp_o
);

    localparam int PPW = width1 + 2;

    logic signed [PPW-1:0] a_ext;
    logic signed [PPW-1:0] d_ext;

    always_comb begin
        a_ext = {{2{a_i[width1-1]}}, a_i};
        if (last_step_i == DIGIT_SIGNED) begin
            d_ext = {{(PPW-2){digit_i[1]}}, digit_i};
        end else begin
            d_ext = {{(PPW-2){1'b0}}, digit_i};
        end
        // |A*3| < 2^(width1+1), so truncating to PPW bits is exact
        pp_o = a_ext * d_ext;
    end

endmodule

// File: rtl/booth2_seq_mul_ctrl.sv
// Sequential signed multiplier: walks B two bits per cycle and shift-accumulates A*digit.
// Define BOOTH2_SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining B bits are zero.
module booth2_seq_mul_ctrl
    import booth2_pkg::*;
#(
    parameter int width1 = WIDTH1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [width1-1:0]   in_a,
    input  logic signed [width1-1:0]   in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [2*width1-1:0] out_p,
    output logic                       busy
);

    localparam int N_STEPS = width1 / 2;
    localparam int PPW     = width1 + 2;
    localparam int PW      = 2 * width1;
    localparam int CNT_W   = $clog2(N_STEPS);

    state_t                   state_q, state_d;
    logic signed [width1-1:0] a_q, a_d;
    logic signed [width1-1:0] b_q, b_d;
    logic signed [PW-1:0]     acc_q, acc_d;
    logic signed [PW-1:0]     p_q, p_d;
    logic [CNT_W-1:0]         step_q, step_d;

    logic                     last_step;
    logic                     done_now;
    logic signed [PPW-1:0]    pp;
    logic signed [PW-1:0]     term;
    logic signed [PW-1:0]     acc_sum;
    logic signed [width1-1:0] b_rest;

    // b_q is shifted right by two each step, so the current digit is always b_q[1:0]
    booth2_pp_gen #(.width1(width1)) u_pp_gen (
        .a_i         (a_q),
        .digit_i     (b_q[1:0]),
        .last_step_i (last_step),
        .pp_o        (pp)
    );

    always_comb begin
        last_step = (step_q == CNT_W'(N_STEPS - 1));
        b_rest    = b_q >>> 2;
        term      = $signed({{(PW-PPW){pp[PPW-1]}}, pp}) <<< (2 * step_q);
        acc_sum   = acc_q + term;
`ifdef BOOTH2_SEQ_MUL_EARLY_TERM_EN
        // Arithmetic shift keeps negative B nonzero, so negative B always runs every step
        done_now  = last_step || (b_rest == '0);
`else
        done_now  = last_step;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_sum;
                b_d    = b_rest;
                step_d = step_q + CNT_W'(1);
                if (done_now) begin
                    p_d     = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            step_q  <= step_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_p     = p_q;

endmodule

// File: tb/tb_booth2_seq_mul_ctrl.sv
// Directed and table-driven bench for booth2_seq_mul_ctrl (default width1=16).
module tb_booth2_seq_mul_ctrl;

    localparam int W     = 16;
    localparam int STEPS = W / 2;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_a;
    logic signed [W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W-1:0] out_p;
    logic                  busy;

    int checks;
    int failures;

    booth2_seq_mul_ctrl #(.width1(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0]   a;
        logic signed [W-1:0]   b;
        logic signed [2*W-1:0] p;
        int                    hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic signed [W-1:0] b);
`ifdef BOOTH2_SEQ_MUL_EARLY_TERM_EN
        int n;
        if (b < 0) return STEPS;
        n = 1;
        for (int i = 1; i < STEPS; i++) begin
            if ((b >>> (2 * i)) != 0) n = i + 1;
        end
        return n;
`else
        return STEPS;
`endif
    endfunction

    // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
    task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input logic signed [2*W-1:0] p, input int hold);
        int lat;
        chk("idle_ready", in_ready, 1'b1);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            chk("run_in_ready", in_ready, 1'b0);
            chk("run_busy", busy, 1'b1);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_lat(b));
        chk("product", out_p, p);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = 16'sh1111;
            in_b     = 16'sh2222;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_stable", out_p, p);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", out_valid, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_busy", busy, 1'b0);
        chk("release_keep_p", out_p, p);
        out_ready = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        vecs[0]  = '{16'sd3,      16'sd5,      32'h0000000F, 0};
        vecs[1]  = '{-16'sd32768, -16'sd32768, 32'h40000000, 0};
        vecs[2]  = '{16'sd32767,  -16'sd32768, 32'hC0008000, 0};
        vecs[3]  = '{-16'sd1,     16'sd1,      32'hFFFFFFFF, 1};
        vecs[4]  = '{16'sd100,    -16'sd7,     32'hFFFFFD44, 5};
        vecs[5]  = '{16'sd2,      16'sd3,      32'h00000006, 0};
        vecs[6]  = '{-16'sd9,     16'sd3,      32'hFFFFFFE5, 0};
        vecs[7]  = '{16'sd1234,   16'sd0,      32'h00000000, 0};
        vecs[8]  = '{16'sd1234,   -16'sd1,     32'hFFFFFB2E, 2};
        vecs[9]  = '{16'sd1234,   16'sd567,    32'h000AAD1E, 0};
        vecs[10] = '{16'sd32767,  16'sd32767,  32'h3FFF0001, 0};
        vecs[11] = '{-16'sd5,     16'sd16384,  32'hFFFEC000, 3};

        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, 32'h0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold);
        end

        // Abort mid-operation: outputs must drop to reset values without waiting for a clock
        in_a     = 16'sd1234;
        in_b     = 16'sd567;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_p", out_p, 32'h0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_output", out_valid, 1'b0);
        end
        do_op(16'sd2, 16'sd3, 32'sd6, 0);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
